pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch over a request/grant/response memory interface.
- Selects the next PC each fetch:
  - sequential PC+4,
  - taken-branch target from the PC+immediate adder,
  - JALR target.
- Sits between execute-stage redirect logic and the instruction memory.
- Presents one fetched instruction at a time to decode, with stall hold and redirect kill.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- PC_INCR, 4, sequential increment in bytes.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- stall_i  input  1  decode cannot accept; hold the presented instruction.
- branch_taken_i  input  1  one-cycle pulse; take branch_target_i.
- branch_target_i  input  32  PC+imm result from the branch adder.
- jalr_i  input  1  one-cycle pulse; take jalr_target_i with bit 0 cleared.
- jalr_target_i  input  32  rs1+imm.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  32  fetch address; stable while imem_req_o=1 and not granted.
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  response data valid (exactly one per grant, ≥1 cycle after grant).
- imem_rdata_i  input  32  instruction word.
- instr_valid_o  output  1  instr_o/instr_pc_o valid.
- instr_o  output  32  fetched instruction.
- instr_pc_o  output  32  PC of instr_o.
- misalign_o  output  1  one-cycle pulse: redirect target not word-aligned.

Behaviour:
- Reset (synchronous): pc=RESET_VECTOR, state=IDLE, kill=0, pending=0. All outputs are 0, except imem_addr_o, which equals pc.
- States: IDLE, REQ, WAIT, OUT. All outputs are registered or decoded from registered state only; no combinational input-to-output paths.
- IDLE: unconditionally to REQ next cycle. A redirect seen in IDLE loads pc directly.
- REQ: imem_req_o=1, imem_addr_o=pc. On imem_gnt_i, go to WAIT. Otherwise stay, with the address held.
- WAIT: on imem_rvalid_i:
  - kill=1: discard data, pc<=pending_pc, kill<=0, go to REQ.
  - kill=0: instr_o<=rdata, instr_pc_o<=pc, instr_valid_o<=1, go to OUT.
- OUT:
  - stall_i=1 and no redirect: hold everything.
  - stall_i=0: pc<=pc+PC_INCR, instr_valid_o<=0, go to REQ.
- Fetch latency: best case 3 cycles per instruction (REQ with gnt, WAIT with rvalid, OUT unstalled). No overlap of fetches.
- Redirect target: jalr_i has priority over branch_taken_i if both are pulsed; tgt = jalr ? {jalr_target_i[31:1],1'b0} : branch_target_i.
- Misaligned target: tgt[1:0]!=0 sets misalign_o=1 for the next cycle. The redirect is ignored; state and pc are unchanged.
- Aligned redirect, by state:
  - IDLE: pc<=tgt.
  - REQ without gnt: kill<=1, pending_pc<=tgt. The request stays with its old address (stability rule).
  - REQ with gnt: kill<=1, pending_pc<=tgt, go to WAIT.
  - WAIT: kill<=1, pending_pc<=tgt. If rvalid arrives the same cycle, that response is discarded and pc<=tgt directly.
  - OUT: overrides stall_i; instr_valid_o<=0, pc<=tgt, go to REQ.
- Back-to-back redirects before the kill resolves: newest target wins; kill stays 1.
- REQ, kill=1, then granted: response discarded as in WAIT.
- Arithmetic: 32-bit, modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset mid-operation overrides everything and returns to IDLE. The memory shares rst_i, so no stale rvalid follows.

Decomposition:
- Shared package riscv_pkg holds:
  - enum fetch_state_e {IDLE, REQ, WAIT, OUT},
  - localparam PC_INCR,
  - localparam RESET_VECTOR default.
- One natural sub-module, pc_redirect_ctrl. It contains the priority, alignment check, and kill/pending_pc registers, and outputs redirect_now, redirect_pc, kill and misalign.

Test Plan:
1. Reset vector: reset with RESET_VECTOR=32'h0000_1000, then memory grants immediately with rvalid one cycle later → requests at 1000, 1004, 1008. instr_pc_o matches each; instr_valid_o high one cycle per instruction.
2. Stall: stall_i=1 for 5 cycles in OUT at pc 1004 → instr_o, instr_pc_o and instr_valid_o are held, with no imem_req_o. Release → next request at 1008.
3. Redirect in flight: branch_taken_i with target 2000 in WAIT of fetch 1008 → that response is discarded (instr_valid_o stays 0). Next request at 2000, instr_pc_o=2000.
4. JALR priority and bit clear: jalr_i with target 3001 and branch_taken_i with target 4000 in the same cycle in OUT → next request at 3000.
5. Misaligned target: branch target 2002 → misalign_o pulses once. The fetch sequence continues at pc+4 unaffected.
6. Delayed grant, then reset: grant held off 4 cycles → imem_addr_o stable for the whole wait. Reset asserted in WAIT → IDLE next cycle, then refetch from RESET_VECTOR. Also check the wrap case: pc 32'hFFFF_FFFC advances to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: sequencer state encoding, PC step and reset
// vector defaults, plus a small alignment helper used by the redirect logic.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_INCR              = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // True when the address points at a 32-bit instruction boundary.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr & 32'h0000_0003) == 32'h0000_0000;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request/grant/response bus. The fetch sequencer is the
// master; the instruction memory (or a testbench model of it) is the slave.
interface pc_fetch_sequencer_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/pc_redirect_ctrl.sv
// Redirect front end for the fetch sequencer. Picks the redirect target
// (JALR beats branch), rejects misaligned targets with a one-cycle flag, and
// decides whether a redirect can be applied to the PC right now or must be
// parked as a pending target while an in-flight fetch is killed.
module pc_redirect_ctrl
  import riscv_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  fetch_state_e state_i,
  input  logic         rvalid_i,
  input  logic         branch_taken_i,
  input  logic [31:0]  branch_target_i,
  input  logic         jalr_i,
  input  logic [31:0]  jalr_target_i,
  output logic         redirect_now_o,
  output logic [31:0]  redirect_pc_o,
  output logic         kill_o,
  output logic [31:0]  pending_pc_o,
  output logic         misalign_o
);

  logic        redirect_req;
  logic        redirect_ok;
  logic [31:0] target;
  logic        kill_d,       kill_q;
  logic [31:0] pending_pc_d, pending_pc_q;
  logic        misalign_d,   misalign_q;

  // Select the target, classify it, and work out the kill/pending update.
  // In IDLE and OUT nothing is in flight, so the PC can be redirected at
  // once; in REQ/WAIT the outstanding fetch must be killed first unless its
  // response lands this very cycle, in which case it is simply dropped.
  always_comb begin
    redirect_req   = jalr_i | branch_taken_i;
    target         = jalr_i ? (jalr_target_i & 32'hFFFF_FFFE) : branch_target_i;
    redirect_ok    = redirect_req && is_word_aligned(target);
    misalign_d     = redirect_req && !is_word_aligned(target);
    redirect_now_o = 1'b0;
    kill_d         = kill_q;
    pending_pc_d   = pending_pc_q;
    unique case (state_i)
      IDLE, OUT: begin
        redirect_now_o = redirect_ok;
      end
      REQ: begin
        if (redirect_ok) begin
          kill_d       = 1'b1;
          pending_pc_d = target;
        end
      end
      WAIT: begin
        if (rvalid_i) begin
          kill_d         = 1'b0;
          redirect_now_o = redirect_ok;
        end else if (redirect_ok) begin
          kill_d       = 1'b1;
          pending_pc_d = target;
        end
      end
      default: begin
        redirect_now_o = 1'b0;
      end
    endcase
  end

  // Kill flag, parked target and misalignment pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kill_q       <= 1'b0;
      pending_pc_q <= 32'h0000_0000;
      misalign_q   <= 1'b0;
    end else begin
      kill_q       <= kill_d;
      pending_pc_q <= pending_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  assign redirect_pc_o = target;
  assign kill_o        = kill_q;
  assign pending_pc_o  = pending_pc_q;
  assign misalign_o    = misalign_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// Walks IDLE -> REQ -> WAIT -> OUT for every instruction, presenting one
// fetched word at a time to decode, holding it under stall and dropping it
// (or the in-flight fetch) when execute redirects the PC.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = riscv_pkg::DEFAULT_RESET_VECTOR,
  parameter int unsigned PC_INCR      = riscv_pkg::PC_INCR
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        stall_i,
  input  logic                        branch_taken_i,
  input  logic [31:0]                 branch_target_i,
  input  logic                        jalr_i,
  input  logic [31:0]                 jalr_target_i,
  pc_fetch_sequencer_if.master        imem_bus,
  output logic                        instr_valid_o,
  output logic [31:0]                 instr_o,
  output logic [31:0]                 instr_pc_o,
  output logic                        misalign_o
);

  import riscv_pkg::*;

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  instr_d, instr_q;
  logic [31:0]  instr_pc_d, instr_pc_q;
  logic         instr_valid_d, instr_valid_q;

  logic         redirect_now;
  logic [31:0]  redirect_pc;
  logic         kill;
  logic [31:0]  pending_pc;

  pc_redirect_ctrl u_redirect (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .state_i         (state_q),
    .rvalid_i        (imem_bus.imem_rvalid_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jalr_i          (jalr_i),
    .jalr_target_i   (jalr_target_i),
    .redirect_now_o  (redirect_now),
    .redirect_pc_o   (redirect_pc),
    .kill_o          (kill),
    .pending_pc_o    (pending_pc),
    .misalign_o      (misalign_o)
  );

  // Next-state logic. The PC only moves when no fetch is outstanding, so the
  // request address stays stable from REQ entry until the grant.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_now) begin
          pc_d = redirect_pc;
        end
      end
      REQ: begin
        if (imem_bus.imem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_bus.imem_rvalid_i) begin
          if (redirect_now) begin
            pc_d    = redirect_pc;
            state_d = REQ;
          end else if (kill) begin
            pc_d    = pending_pc;
            state_d = REQ;
          end else begin
            instr_d       = imem_bus.imem_rdata_i;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = OUT;
          end
        end
      end
      OUT: begin
        if (redirect_now) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_pc;
          state_d       = REQ;
        end else if (!stall_i) begin
          instr_valid_d = 1'b0;
          pc_d          = pc_q + 32'(PC_INCR);
          state_d       = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, PC and presented-instruction registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      instr_q       <= 32'h0000_0000;
      instr_pc_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_bus.imem_req_o  = (state_q == REQ);
  assign imem_bus.imem_addr_o = pc_q;
  assign instr_valid_o        = instr_valid_q;
  assign instr_o              = instr_q;
  assign instr_pc_o           = instr_pc_q;

endmodule
